// File: rtl/instr_enc_pkg.sv
// Shared encodings for the instruction encoder/loader: mnemonic codes,
// RV32I opcode/funct constants, internal format classes and FSM states.
package instr_enc_pkg;

  typedef enum logic [4:0] {
    MN_ADDI  = 5'd0,  MN_XORI = 5'd1,  MN_ORI  = 5'd2,  MN_ANDI = 5'd3,
    MN_SLTIU = 5'd4,  MN_SLTI = 5'd5,  MN_SLLI = 5'd6,  MN_SRLI = 5'd7,
    MN_SRAI  = 5'd8,  MN_ADD  = 5'd9,  MN_XOR  = 5'd10, MN_OR   = 5'd11,
    MN_AND   = 5'd12, MN_SUB  = 5'd13, MN_SLL  = 5'd14, MN_SRL  = 5'd15,
    MN_SRA   = 5'd16, MN_SLTU = 5'd17, MN_SLT  = 5'd18, MN_SW   = 5'd19,
    MN_BNE   = 5'd20
  } mnem_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {FMT_I, FMT_SH, FMT_R, FMT_S, FMT_B, FMT_ILL} fmt_e;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_e;

endpackage

// File: rtl/instr_encode.sv
// Combinational RV32I encoder: symbolic mnemonic plus fields in,
// 32-bit instruction word and illegal-mnemonic flag out.
module instr_encode
  import instr_enc_pkg::*;
(
  input  logic [4:0]  mnem_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [11:0] imm12_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  fmt_e       fmt;
  logic [2:0] f3;
  logic [6:0] f7;

  // Classify mnemonic into an instruction format with its funct fields
  always_comb begin
    fmt = FMT_ILL;
    f3  = F3_ADD;
    f7  = F7_BASE;
    case (mnem_i)
      MN_ADDI:  begin fmt = FMT_I;  f3 = F3_ADD;  end
      MN_XORI:  begin fmt = FMT_I;  f3 = F3_XOR;  end
      MN_ORI:   begin fmt = FMT_I;  f3 = F3_OR;   end
      MN_ANDI:  begin fmt = FMT_I;  f3 = F3_AND;  end
      MN_SLTIU: begin fmt = FMT_I;  f3 = F3_SLTU; end
      MN_SLTI:  begin fmt = FMT_I;  f3 = F3_SLT;  end
      MN_SLLI:  begin fmt = FMT_SH; f3 = F3_SLL;  end
      MN_SRLI:  begin fmt = FMT_SH; f3 = F3_SR;   end
      MN_SRAI:  begin fmt = FMT_SH; f3 = F3_SR;   f7 = F7_ALT; end
      MN_ADD:   begin fmt = FMT_R;  f3 = F3_ADD;  end
      MN_XOR:   begin fmt = FMT_R;  f3 = F3_XOR;  end
      MN_OR:    begin fmt = FMT_R;  f3 = F3_OR;   end
      MN_AND:   begin fmt = FMT_R;  f3 = F3_AND;  end
      MN_SUB:   begin fmt = FMT_R;  f3 = F3_ADD;  f7 = F7_ALT; end
      MN_SLL:   begin fmt = FMT_R;  f3 = F3_SLL;  end
      MN_SRL:   begin fmt = FMT_R;  f3 = F3_SR;   end
      MN_SRA:   begin fmt = FMT_R;  f3 = F3_SR;   f7 = F7_ALT; end
      MN_SLTU:  begin fmt = FMT_R;  f3 = F3_SLTU; end
      MN_SLT:   begin fmt = FMT_R;  f3 = F3_SLT;  end
      MN_SW:    begin fmt = FMT_S;  f3 = F3_SW;   end
      MN_BNE:   begin fmt = FMT_B;  f3 = F3_BNE;  end
      default:  fmt = FMT_ILL;
    endcase
  end

  // Assemble fields; BNE immediate is offset[12:1], so bit positions shift by one
  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (fmt)
      FMT_I:   word_o = {imm12_i, rs1_i, f3, rd_i, OP_IMM};
      FMT_SH:  word_o = {f7, imm12_i[4:0], rs1_i, f3, rd_i, OP_IMM};
      FMT_R:   word_o = {f7, rs2_i, rs1_i, f3, rd_i, OP_REG};
      FMT_S:   word_o = {imm12_i[11:5], rs2_i, rs1_i, f3, imm12_i[4:0], OP_STORE};
      FMT_B:   word_o = {imm12_i[11], imm12_i[9:4], rs2_i, rs1_i, f3,
                         imm12_i[3:0], imm12_i[10], OP_BRANCH};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts symbolic instructions over valid/ready, encodes
// them and writes one word per accept sequentially into instruction memory.
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm12,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;

  logic [31:0]         enc_word;
  logic                enc_illegal;
  logic                accept;

  instr_encode u_encode (
    .mnem_i    (in_mnem),
    .rd_i      (in_rd),
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .imm12_i   (in_imm12),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  // count already includes the in-flight write, so no separate pending term is needed
  assign in_ready = (state_q == ST_LOAD) && (count_q < CNT_W'(DEPTH));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (enc_illegal) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = enc_word;
            ptr_d   = ptr_q + ADDR_W'(1);
            count_d = count_q + CNT_W'(1);
          end
        end
        if (finish || (count_d == CNT_W'(DEPTH))) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;
  assign busy       = (state_q == ST_LOAD);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: stimulus pushes expected writes
// from a field-arithmetic reference encoder; a monitor pops on every imem_we.
module tb_instr_encoder_loader;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, finish, in_valid, in_ready;
  logic [4:0]        in_mnem, in_rd, in_rs1, in_rs2;
  logic [11:0]       in_imm12;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  // reference session state
  int m_cnt  = 0;
  bit m_err  = 1'b0;
  bit m_load = 1'b0;
  bit m_done = 1'b0;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm12(in_imm12),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from field weights and the branch byte offset
  function automatic logic [31:0] ref_enc(input int m, input int rd, input int rs1,
                                          input int rs2, input int imm, output bit ok);
    int     f3_i[6]  = '{0, 4, 6, 7, 3, 2};
    int     f3_sh[3] = '{1, 5, 5};
    int     f3_r[10] = '{0, 4, 6, 7, 0, 1, 5, 5, 3, 2};
    longint w;
    longint boff;
    ok = 1'b1;
    w  = 0;
    if (m <= 5) begin
      w = imm * 64'd1048576 + rs1 * 32768 + f3_i[m] * 4096 + rd * 128 + 19;
    end else if (m <= 8) begin
      w = ((m == 8) ? 32 : 0) * 64'd33554432 + (imm % 32) * 1048576
        + rs1 * 32768 + f3_sh[m-6] * 4096 + rd * 128 + 19;
    end else if (m <= 18) begin
      w = ((m == 13 || m == 16) ? 32 : 0) * 64'd33554432 + rs2 * 1048576
        + rs1 * 32768 + f3_r[m-9] * 4096 + rd * 128 + 51;
    end else if (m == 19) begin
      w = (imm / 32) * 64'd33554432 + rs2 * 1048576 + rs1 * 32768
        + 2 * 4096 + (imm % 32) * 128 + 35;
    end else if (m == 20) begin
      boff = longint'(imm) * 2;
      w = ((boff >> 12) & 1) * 64'd2147483648 + ((boff >> 5) & 63) * 33554432
        + rs2 * 1048576 + rs1 * 32768 + 1 * 4096
        + ((boff >> 1) & 15) * 256 + ((boff >> 11) & 1) * 128 + 99;
    end else begin
      ok = 1'b0;
    end
    return w[31:0];
  endfunction

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(count), 32'(m_cnt));
    check({tag, "_err"},   32'(err),   32'(m_err));
    check({tag, "_busy"},  32'(busy),  32'(m_load));
    check({tag, "_done"},  32'(done),  32'(m_done));
  endtask

  // Present one instruction for one cycle (called at a negedge)
  task automatic send(input int m, input int rd, input int rs1, input int rs2,
                      input int imm, input bit fin);
    bit          ok;
    bit          exp_rdy;
    logic [31:0] w;
    in_valid = 1'b1;
    in_mnem  = 5'(m);
    in_rd    = 5'(rd);
    in_rs1   = 5'(rs1);
    in_rs2   = 5'(rs2);
    in_imm12 = 12'(imm);
    finish   = fin;
    exp_rdy  = m_load && (m_cnt < int'(DEPTH));
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (exp_rdy) begin
      w = ref_enc(m, rd, rs1, rs2, imm, ok);
      if (ok) begin
        exp_q.push_back('{addr: m_cnt % (1 << ADDR_W), data: w});
        m_cnt++;
      end else begin
        m_err = 1'b1;
      end
    end
    if (m_load && (fin || m_cnt == int'(DEPTH))) begin
      m_load = 1'b0;
      m_done = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish   = 1'b0;
    check_status("post_send");
  endtask

  task automatic send_gold(input int m, input int rd, input int rs1, input int rs2,
                           input int imm, input logic [31:0] gold);
    send(m, rd, rs1, rs2, imm, 1'b0);
    check("gold_we",    32'(imem_we), 32'd1);
    check("gold_wdata", imem_wdata,   gold);
  endtask

  task automatic pulse_start(input bit with_finish);
    start  = 1'b1;
    finish = with_finish;
    if (!m_load) begin
      m_load = 1'b1;
      m_done = 1'b0;
      m_cnt  = 0;
      m_err  = 1'b0;
    end
    @(negedge clk);
    start  = 1'b0;
    finish = 1'b0;
    check_status("start");
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    if (m_load) begin
      m_load = 1'b0;
      m_done = 1'b1;
    end
    @(negedge clk);
    finish = 1'b0;
    check_status("finish");
  endtask

  // Monitor: every write must match the oldest expected write
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && imem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  initial begin
    int n;
    int m;
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    in_mnem = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm12 = '0;
    repeat (3) @(negedge clk);
    check("rst_we",    32'(imem_we),   32'd0);
    check("rst_addr",  32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata,     32'd0);
    check("rst_ready", 32'(in_ready),  32'd0);
    check_status("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // directed program fills DEPTH
    pulse_start(1'b0);
    send_gold(0, 1, 0, 0, 5, 32'h00500093);
    check("addi_count", 32'(count), 32'd1);
    send_gold(13, 3, 1, 2, 0, 32'h402081B3);
    send_gold(19, 0, 1, 2, 8, 32'h0020A423);
    pulse_start(1'b0);
    send_gold(20, 0, 1, 2, 12'hFFE, 32'hFE209EE3);
    check("full_done",  32'(done),     32'd1);
    check("full_count", 32'(count),    32'(DEPTH));
    check("full_ready", 32'(in_ready), 32'd0);
    send(0, 1, 1, 1, 1, 1'b0);
    check("full_no_we", 32'(imem_we),  32'd0);

    // shift immediate, illegal mnemonic, start-wins over finish
    pulse_start(1'b0);
    send_gold(8, 5, 5, 0, 12'hFE3, 32'h4032D293);
    send(25, 1, 1, 1, 1, 1'b0);
    check("ill_no_we", 32'(imem_we), 32'd0);
    check("ill_err",   32'(err),     32'd1);
    pulse_finish();
    pulse_start(1'b1);
    check("restart_err", 32'(err), 32'd0);

    // accept with finish in the same cycle still writes
    send(2, 7, 3, 0, 12'h0A5, 1'b1);
    check("fin_we", 32'(imem_we), 32'd1);

    // reset mid-session aborts the pending accept
    pulse_start(1'b0);
    send(11, 4, 2, 3, 0, 1'b0);
    in_valid = 1'b1; in_mnem = 5'd9; in_rd = 5'd1; in_rs1 = 5'd2; in_rs2 = 5'd3;
    #2 rst_n = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    m_load = 1'b0; m_done = 1'b0; m_cnt = 0; m_err = 1'b0;
    check("abort_we",    32'(imem_we),   32'd0);
    check("abort_addr",  32'(imem_addr), 32'd0);
    check("abort_wdata", imem_wdata,     32'd0);
    check_status("abort");
    rst_n = 1'b1;
    @(negedge clk);

    // randomized sessions
    repeat (60) begin
      pulse_start($urandom_range(0, 3) == 0);
      n = $urandom_range(1, 6);
      for (int i = 0; i < n && m_load; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        m = ($urandom_range(0, 15) == 0) ? $urandom_range(21, 31) : $urandom_range(0, 20);
        send(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 4095), $urandom_range(0, 5) == 0);
      end
      if (m_load) pulse_finish();
    end

    repeat (3) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
